fetch_sequencer: RTL and testbench

- Controller for the fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and drives a variable-latency instruction-memory handshake (req/gnt, then rvalid).
- Sequences fetch around decode stalls and execute-stage branch redirects, and presents InstrD, PCD, PCPlus4D and ValidD to decode.
- One request outstanding at most.

---
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, runs a one-outstanding req/gnt/rvalid imem handshake and
// feeds the decode register. Define FETCH_PERF_CNT_EN to add saturating performance counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCSrcE,
  input  logic [31:0]       PCTargetE,
  input  logic              StallD,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_killed,
  output logic [PERF_W-1:0] perf_wait
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] target;
  logic        granted, resp, resp_drop, resp_take;
  logic        buf_fill, buf_drop, load_wait, load_hold;

  assign target    = PCTargetE & 32'hFFFF_FFFC;
  assign granted   = (state_q == StReq) && imem_gnt;
  assign resp      = (state_q == StWait) && imem_rvalid;
  // A redirect in the same cycle as the response makes that response stale too.
  assign resp_drop = resp && (kill_q || PCSrcE);
  assign resp_take = resp && !resp_drop;
  assign buf_fill  = resp_take && StallD;
  assign load_wait = resp_take && !StallD;
  assign buf_drop  = (state_q == StHold) && PCSrcE;
  assign load_hold = (state_q == StHold) && !PCSrcE && !StallD;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (imem_gnt) state_d = StWait;
      StWait: if (resp) state_d = buf_fill ? StHold : StReq;
      StHold: if (PCSrcE || !StallD) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state_q == StReq);
    imem_addr = pc_q;
    InstrD    = instr_q;
    PCD       = pcd_q;
    PCPlus4D  = pcp4_q;
    ValidD    = valid_q;
  end

  // PC, outstanding-request tracking and skid buffer
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (PCSrcE) begin
      pc_d = target;
    end else if (granted) begin
      pc_d = pc_q + 32'd4;
    end
    if (granted) begin
      req_pc_d = pc_q;
    end
    if (resp) begin
      kill_d = 1'b0;
    end else if (PCSrcE && (granted || state_q == StWait)) begin
      kill_d = 1'b1;
    end
    if (buf_fill) begin
      buf_instr_d = imem_rdata;
      buf_pc_d    = req_pc_q;
    end
  end

  // Decode register: flush beats stall; without new work an unstalled register bubbles.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (PCSrcE) begin
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (load_wait) begin
        instr_d = imem_rdata;
        pcd_d   = req_pc_q;
        pcp4_d  = req_pc_q + 32'd4;
        valid_d = 1'b1;
      end else if (load_hold) begin
        instr_d = buf_instr_q;
        pcd_d   = buf_pc_q;
        pcp4_d  = buf_pc_q + 32'd4;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      kill_q      <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      instr_q     <= 32'h0;
      pcd_q       <= 32'h0;
      pcp4_q      <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pcp4_q      <= pcp4_d;
      valid_q     <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] fetched_q, fetched_d, killed_q, killed_d, wait_q, wait_d;
  logic              fetched_inc, killed_inc, wait_inc;

  assign fetched_inc = load_wait || load_hold;
  assign killed_inc  = resp_drop || buf_drop;
  assign wait_inc    = ((state_q == StReq) && !imem_gnt) || ((state_q == StWait) && !imem_rvalid);

  // Saturating increments
  always_comb begin
    fetched_d = fetched_q;
    killed_d  = killed_q;
    wait_d    = wait_q;
    if (fetched_inc && (fetched_q != '1)) fetched_d = fetched_q + 1'b1;
    if (killed_inc && (killed_q != '1))   killed_d  = killed_q + 1'b1;
    if (wait_inc && (wait_q != '1))       wait_d    = wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      killed_q  <= '0;
      wait_q    <= '0;
    end else begin
      fetched_q <= fetched_d;
      killed_q  <= killed_d;
      wait_q    <= wait_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;
  assign perf_wait    = wait_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model (PC, pending/held queues)
// predicts every decode-side output; a second instance covers PC wrap from 32'hFFFFFFFC.
module tb_fetch_sequencer;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam logic [31:0] WrapPc   = 32'hFFFF_FFFC;
  localparam int          PerfMax  = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        stall = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pcp4_d;

  logic        req2, valid2, rv2;
  logic [31:0] addr2, instr2, pcd2, pcp42, a2q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_killed, perf_wait;
  logic [15:0] p2_fetched, p2_killed, p2_wait;
`endif

  fetch_sequencer #(.RESET_PC(ResetPc)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrcE      (pc_src),
    .PCTargetE   (tgt),
    .StallD      (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .InstrD      (instr_d),
    .PCD         (pc_d),
    .PCPlus4D    (pcp4_d),
    .ValidD      (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_killed (perf_killed),
    .perf_wait   (perf_wait)
`endif
  );

  fetch_sequencer #(.RESET_PC(WrapPc)) u_dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .PCSrcE      (1'b0),
    .PCTargetE   (32'h0),
    .StallD      (1'b0),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_gnt    (1'b1),
    .imem_rvalid (rv2),
    .imem_rdata  (mem_word(a2q)),
    .InstrD      (instr2),
    .PCD         (pcd2),
    .PCPlus4D    (pcp42),
    .ValidD      (valid2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(p2_fetched),
    .perf_killed (p2_killed),
    .perf_wait   (p2_wait)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory for the wrap instance: always grants, answers one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv2 <= 1'b0;
      a2q <= 32'h0;
    end else begin
      rv2 <= req2;
      if (req2) a2q <= addr2;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {logic [31:0] pc; bit dead;} pend_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} held_t;

  pend_t       pend_q[$];
  held_t       held_q[$];
  bit          m_bubble;
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
  bit          m_valid;
  int          m_fetched, m_killed, m_wait;

  bit          mem_pend;
  logic [31:0] mem_addr;
  int          cyc;

  function automatic int sat_inc(input int v);
    return (v < PerfMax) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_bubble = 1'b1;
    m_pc     = ResetPc;
    pend_q.delete();
    held_q.delete();
    m_valid  = 1'b0;
    m_instr  = 32'h0;
    m_pcd    = 32'h0;
    m_pcp4   = 32'h0;
    m_fetched = 0;
    m_killed  = 0;
    m_wait    = 0;
  endtask

  task automatic model_step();
    bit    requesting;
    bit    have;
    held_t dlv;
    pend_t p;
    requesting = !m_bubble && pend_q.size() == 0 && held_q.size() == 0;
    have = 1'b0;
    if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (held_q.size() != 0) begin
      if (pc_src) begin
        held_q.delete();
        m_killed = sat_inc(m_killed);
      end else if (!stall) begin
        dlv  = held_q.pop_front();
        have = 1'b1;
      end
    end else if (pend_q.size() != 0) begin
      if (rvalid) begin
        p = pend_q.pop_front();
        if (p.dead || pc_src) m_killed = sat_inc(m_killed);
        else if (stall) held_q.push_back('{instr: mem_word(p.pc), pc: p.pc});
        else begin
          dlv  = '{instr: mem_word(p.pc), pc: p.pc};
          have = 1'b1;
        end
      end else begin
        m_wait = sat_inc(m_wait);
        if (pc_src) pend_q[0].dead = 1'b1;
      end
    end else if (requesting) begin
      if (gnt) pend_q.push_back('{pc: m_pc, dead: pc_src});
      else m_wait = sat_inc(m_wait);
    end
    if (pc_src) m_pc = tgt & 32'hFFFF_FFFC;
    else if (requesting && gnt) m_pc = m_pc + 32'd4;
    if (pc_src) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = have;
      if (have) begin
        m_instr   = dlv.instr;
        m_pcd     = dlv.pc;
        m_pcp4    = dlv.pc + 32'd4;
        m_fetched = sat_inc(m_fetched);
      end
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !m_bubble && pend_q.size() == 0 && held_q.size() == 0;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("ValidD", valid_d, m_valid);
    check("InstrD", instr_d, m_instr);
    check("PCD", pc_d, m_pcd);
    check("PCPlus4D", pcp4_d, m_pcp4);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_killed", perf_killed, m_killed);
    check("perf_wait", perf_wait, m_wait);
`endif
  endtask

  // mode 0: ideal memory with two directed redirects; 1: random; 2: stray rvalid, no grant
  task automatic choose(input int mode);
    unique case (mode)
      0: begin
        pc_src = (cyc == 9) || (cyc == 14);
        tgt    = (cyc == 9) ? 32'h103 : 32'h40;
        stall  = 1'b0;
        gnt    = 1'b1;
        rvalid = mem_pend;
        rdata  = mem_word(mem_addr);
      end
      1: begin
        pc_src = ($urandom_range(7) == 0);
        tgt    = $urandom;
        stall  = ($urandom_range(2) == 0);
        gnt    = $urandom_range(1);
        if (mem_pend) begin
          rvalid = $urandom_range(1);
          rdata  = mem_word(mem_addr);
        end else begin
          rvalid = ($urandom_range(5) == 0);
          rdata  = $urandom;
        end
      end
      default: begin
        pc_src = 1'b0;
        stall  = 1'b0;
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
      end
    endcase
  endtask

  task automatic do_cycle(input int mode);
    compare();
    choose(mode);
    if (rvalid && mem_pend) mem_pend = 1'b0;
    else if (imem_req && gnt) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
    end
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  // Wrap instance: first two fetches at 0xFFFFFFFC then 0x0.
  initial begin : wrap_check
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic [31:0] p4s[$];
    logic [31:0] ins[$];
    wait (rst == 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req2) addrs.push_back(addr2);
      if (valid2) begin
        pcs.push_back(pcd2);
        p4s.push_back(pcp42);
        ins.push_back(instr2);
      end
    end
    check("wrap_nreq", addrs.size() >= 2, 1);
    check("wrap_nvalid", pcs.size() >= 2, 1);
    if (addrs.size() >= 2) begin
      check("wrap_addr0", addrs[0], WrapPc);
      check("wrap_addr1", addrs[1], 32'h0);
    end
    if (pcs.size() >= 2) begin
      check("wrap_pcd0", pcs[0], WrapPc);
      check("wrap_pcp4_0", p4s[0], 32'h0);
      check("wrap_instr0", ins[0], mem_word(WrapPc));
      check("wrap_pcd1", pcs[1], 32'h0);
      check("wrap_pcp4_1", p4s[1], 32'h4);
    end
  end

  initial begin : main
    bit found;
    model_reset();
    mem_pend = 1'b0;
    mem_addr = 32'h0;
    cyc      = 0;
    repeat (3) @(negedge clk);
    check("rst_addr", imem_addr, ResetPc);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) do_cycle(0);
    for (int i = 0; i < 3000; i++) do_cycle(1);

    // Reset while a response is outstanding
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      do_cycle(1);
      found = mem_pend;
    end
    check("rst_in_wait_found", found, 1);
    rst = 1'b1;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr2", imem_addr, ResetPc);
    check("rst_valid", valid_d, 0);
    check("rst_instr", instr_d, 0);
    check("rst_pcd", pc_d, 0);
    check("rst_pcp4", pcp4_d, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 0);
    check("rst_perf_killed", perf_killed, 0);
    check("rst_perf_wait", perf_wait, 0);
`endif
    model_reset();
    mem_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_cycle(2);
    do_cycle(2);
    for (int i = 0; i < 500; i++) do_cycle(1);
    compare();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
